alu_operand_fetch: RTL and testbench
====================================

// Module: alu_operand_fetch
// PURPOSE
//   Operand-fetch/issue stage directly upstream of the ALU: holds the 32x32 register file, reads rs/rt,
//   selects the B operand (register or sign-extended immediate) and presents A, B, ALUop to the ALU
//   through a one-entry valid/ready output register. A per-register pending scoreboard stalls reads
//   of destinations not yet written back; the writeback port, fed from the ALU Result path, bypasses into reads.
// PARAMETERS
//   DATA_W   32  operand/result width (ALU is 32-bit; other values unsupported)
//   NREG     32  architectural registers; r0 reads 0, never written, never pending
//   AW        5  register address width, clog2(NREG)
// PORTS
//   clk         in   1    clock, all state on rising edge
//   rst         in   1    synchronous, active-high reset
//   in_valid    in   1    issue request valid
//   in_ready    out  1    stage accepts request this cycle
//   in_rs       in   AW   source A register
//   in_rt       in   AW   source B register
//   in_rd       in   AW   destination register (0 = no writeback)
//   in_imm      in   16   immediate, sign-extended to DATA_W
//   in_use_imm  in   1    1: B = sext(in_imm), rt not read and not hazard-checked
//   in_aluop    in   3    000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes forwarded unchanged
//   out_valid   out  1    A/B/ALUop/rd valid toward ALU
//   out_ready   in   1    ALU side consumes this cycle
//   out_A       out  DATA_W  operand A
//   out_B       out  DATA_W  operand B
//   out_ALUop   out  3    ALU opcode
//   out_rd      out  AW   destination carried alongside
//   wb_en       in   1    writeback strobe (ALU Result)
//   wb_addr     in   AW   writeback register
//   wb_data     in   DATA_W  writeback value
// BEHAVIOUR
//   - Reset: out_valid=0, out_A/out_B=0, out_ALUop=000, out_rd=0, all pending bits 0, all registers 0.
//     Reset mid-transfer discards the held entry; a request presented during rst is not accepted.
//   - Transfers: input when in_valid&in_ready; output when out_valid&out_ready.
//   - in_ready = (!out_valid | out_ready) & !hazard & !rst. It may depend combinationally on in_rs/in_rt;
//     it never depends on in_valid.
//   - hazard = (pend[in_rs] & !(wb_en & wb_addr==in_rs)) | (!in_use_imm & pend[in_rt] & !(wb_en & wb_addr==in_rt)).
//     Same-cycle writeback clears the hazard for that source.
//   - Read bypass: if wb_en & wb_addr==src & src!=0, the operand is wb_data; otherwise the register value.
//     r0 always reads 0.
//   - Latency: one cycle; accepted on edge N -> out_valid with operands after edge N.
//     Full throughput with out_ready held 1.
//   - Output hold: while out_valid & !out_ready, all out_* remain stable. No bubble is inserted on release.
//   - Scoreboard: on accept with in_rd!=0, set pend[in_rd]. On wb_en & wb_addr!=0, clear pend[wb_addr].
//     If both hit the same register in one cycle, set wins (the newer producer). Writes to r0 are ignored.
//   - Register write: on wb_en, regs[wb_addr] <= wb_data, unaffected by stalls.
//   - wb_en to a non-pending register is legal: the write proceeds and the scoreboard is unchanged.
//   - Immediate: B = {{16{in_imm[15]}}, in_imm}. No zero-extend mode.
// STRUCTURE
//   - Shared package alu_defs: ALUOP_AND/OR/ADD/SUB/SLT localparams (3'b000/001/010/110/111),
//     DATA_W, AW. The ALU and this stage both include it.
//   - Sub-module reg_file: 2 async read ports, 1 sync write port, r0 hardwired 0. It has no bypass;
//     bypass and scoreboard stay in alu_operand_fetch.
//   - Output register, scoreboard vector and hazard/bypass logic live at top level. No other sub-modules.
// TESTING
//   1. Reset then idle -> out_valid=0, in_ready=1. Write r1=0x7FFFFFFF, r2=0x00000001 via wb;
//      issue rs=1 rt=2 rd=3 op=010 -> next cycle A=0x7FFFFFFF, B=0x00000001, ALUop=010, rd=3.
//   2. Immediate: rs=1, imm=0xFFF2, use_imm=1, op=110 -> B=0xFFFFFFF2. rt is ignored even if pending.
//   3. RAW stall: issue rd=3, then rs=3 -> in_ready=0 until wb_en rd=3 data=0x80000001;
//      in that same cycle in_ready=1 and next A=0x80000001.
//   4. Backpressure: out_ready=0 for 3 cycles with an entry held -> out_* stable, in_ready=0.
//      Release -> queued request appears the next cycle, no loss or duplicate.
//   5. r0 and simultaneity: wb r0=0xDEADBEEF, then rs=0 -> A=0. Issue rd=5 in the same cycle as
//      wb_addr=5 -> pend[5] stays 1.
//   6. Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, pending cleared, in_ready=1.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: opcodes, datapath widths and the immediate extender.
package alu_defs;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int IMM_W  = 16;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  // Sign-extend a 16-bit immediate to the operand width.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 hardwired to 0.
module reg_file
  import alu_defs::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = NREG,
  parameter int AB = AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AB-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AB-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AB-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [NR];

  // Write port; the whole array is cleared on reset.
  // NOTE: resetting an array prevents RAM-macro inference; done here because every register must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Asynchronous reads with r0 forced to zero.
  always_comb begin
    ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];
  end

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch/issue stage: register read with writeback bypass, RAW scoreboard,
// immediate selection and a one-entry valid/ready output register toward the ALU.
module alu_operand_fetch
  import alu_defs::*;
#(
  parameter int DATA_W = alu_defs::DATA_W,
  parameter int NREG   = alu_defs::NREG,
  parameter int AW     = alu_defs::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic [AW-1:0]     in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_aluop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [2:0]        out_ALUop,
  output logic [AW-1:0]     out_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_next;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              wb_hit_rs;
  logic              wb_hit_rt;
  logic              hazard;
  logic              accept;

  reg_file #(.DW(DATA_W), .NR(NREG), .AB(AW)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_rs),
    .ra_data (rf_a),
    .rb_addr (in_rt),
    .rb_data (rf_b),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // Hazard detection, writeback bypass, handshake and next scoreboard state.
  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    wb_hit_rs = wb_en && (wb_addr == in_rs) && (in_rs != '0);
    wb_hit_rt = wb_en && (wb_addr == in_rt) && (in_rt != '0);

    hazard = (pend[in_rs] && !wb_hit_rs) ||
             (!in_use_imm && pend[in_rt] && !wb_hit_rt);

    in_ready = (!out_valid || out_ready) && !hazard && !rst;
    accept   = in_valid && in_ready;

    opnd_a = wb_hit_rs ? wb_data : rf_a;
    if (in_use_imm)     opnd_b = sext_imm(in_imm);
    else if (wb_hit_rt) opnd_b = wb_data;
    else                opnd_b = rf_b;

    // Clear on writeback first, then set on accept so the newer producer wins.
    pend_next = pend;
    if (wb_en && wb_addr != '0) pend_next[wb_addr] = 1'b0;
    if (accept && in_rd != '0)  pend_next[in_rd]   = 1'b1;
    pend_next[0] = 1'b0;
  end

  // Scoreboard register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  // One-entry output register: load on accept, drop valid once consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_A     <= '0;
      out_B     <= '0;
      out_ALUop <= ALUOP_AND;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_A     <= opnd_a;
      out_B     <= opnd_b;
      out_ALUop <= in_aluop;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: directed scenarios then random traffic,
// all compared against an array-based reference model.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_aluop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A, out_B;
  logic [2:0]  out_ALUop;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_ov;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;

  alu_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_aluop(in_aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_ALUop(out_ALUop), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] src);
    if (src == 0) return 32'd0;
    if (wb_en && wb_addr == src) return wb_data;
    return m_regs[src];
  endfunction

  function automatic logic [31:0] m_sext(input logic [15:0] imm);
    if (imm[15]) return 32'(imm) - 32'h0001_0000;
    return 32'(imm);
  endfunction

  task automatic idle();
    rst = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
    in_use_imm = 0; in_aluop = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] op);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_aluop = op; in_use_imm = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic tick();
    bit hz, exp_ready, acc, was_rst;
    logic [31:0] va, vb;
    #1;
    hz = (m_pend[in_rs] && !(wb_en && wb_addr == in_rs)) ||
         (!in_use_imm && m_pend[in_rt] && !(wb_en && wb_addr == in_rt));
    exp_ready = !rst && (!m_ov || out_ready) && !hz;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = in_valid && exp_ready;
    va  = m_read(in_rs);
    vb  = in_use_imm ? m_sext(in_imm) : m_read(in_rt);
    was_rst = rst;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_ov = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
    end else begin
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 0;
      end
      if (acc && in_rd != 0) m_pend[in_rd] = 1;
      if (acc) begin
        m_ov = 1; m_a = va; m_b = vb; m_op = in_aluop; m_rd = in_rd;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov || was_rst) begin
      check("out_A", out_A, m_a);
      check("out_B", out_B, m_b);
      check("out_ALUop", 32'(out_ALUop), 32'(m_op));
      check("out_rd", 32'(out_rd), 32'(m_rd));
    end
  endtask

  logic [31:0] held_a, held_b;
  logic [4:0]  held_rd;

  initial begin
    idle();
    for (int i = 0; i < 32; i++) begin m_regs[i] = 'x; m_pend[i] = 0; end
    m_ov = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
    @(posedge clk); #1;

    // 1. Reset, idle, basic ADD issue.
    rst = 1; tick(); tick();
    idle(); tick();
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);
    wb(1, 32'h7FFF_FFFF); tick();
    wb(2, 32'h0000_0001); tick();
    idle(); issue(1, 2, 3, 3'b010); tick();
    check("t1_A", out_A, 32'h7FFF_FFFF);
    check("t1_B", out_B, 32'h0000_0001);
    check("t1_op", 32'(out_ALUop), 32'h2);
    check("t1_rd", 32'(out_rd), 32'd3);

    // 2. Immediate with a pending rt (r3) that must be ignored.
    idle(); issue(1, 3, 0, 3'b110); in_use_imm = 1; in_imm = 16'hFFF2; tick();
    check("t2_B", out_B, 32'hFFFF_FFF2);

    // 3. RAW stall on r3 until its writeback, which also bypasses.
    idle(); issue(3, 1, 0, 3'b000); tick(); tick();
    check("t3_stall", 32'(out_valid), 32'd0);
    wb(3, 32'h8000_0001); tick();
    check("t3_A", out_A, 32'h8000_0001);

    // 4. Backpressure: entry held three cycles, queued request released afterwards.
    idle(); issue(1, 2, 4, 3'b111); tick();
    held_a = out_A; held_b = out_B; held_rd = out_rd;
    out_ready = 0; issue(2, 1, 6, 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_A", out_A, held_a);
      check("t4_hold_B", out_B, held_b);
      check("t4_hold_rd", 32'(out_rd), 32'(held_rd));
    end
    out_ready = 1; tick();
    idle(); tick();
    check("t4_drain", 32'(out_valid), 32'd0);

    // 5. r0 writes ignored; issue and writeback to r5 in the same cycle keep r5 pending.
    wb(0, 32'hDEAD_BEEF); tick();
    idle(); issue(0, 0, 0, 3'b010); tick();
    check("t5_r0", out_A, 32'd0);
    idle(); issue(1, 2, 5, 3'b010); wb(5, 32'h1234_5678); tick();
    idle(); issue(5, 0, 0, 3'b010); tick();
    check("t5_pend5", 32'(out_valid), 32'd0);
    wb(5, 32'h0000_0055); tick();

    // 6. Reset while an entry is held under backpressure.
    idle(); issue(1, 2, 7, 3'b010); tick();
    out_ready = 0; in_valid = 0; tick();
    rst = 1; tick();
    check("t6_valid", 32'(out_valid), 32'd0);
    idle(); issue(5, 7, 0, 3'b010); tick();
    check("t6_accept", 32'(out_valid), 32'd1);

    // Random traffic over a small register window to provoke hazards and bypasses.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      in_valid   = $urandom_range(0, 1);
      in_rs      = 5'($urandom_range(0, 7));
      in_rt      = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_imm     = 16'($urandom);
      in_use_imm = ($urandom_range(0, 3) == 0);
      in_aluop   = 3'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_en      = $urandom_range(0, 1);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
